sequence_generator: RTL and testbench

Serial frame transmitter that drives the single-bit serial line consumed by sequence_detector. It accepts a parallel payload word with a start/ready handshake. It then emits a fixed sync preamble (default 1010), followed by the payload MSB-first, one bit per clock, and finally a run of idle-low gap cycles so the downstream detector can re-arm. It sits upstream of the detector in the serial link path and is the stimulus source for link-level tests.

---
 rtl/sequence_generator.sv | 152 +++++++++++++++
 tb/tb_sequence_generator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// sequence_generator: serial frame transmitter. It sends a sync preamble,
// then the latched payload MSB-first, then GAP_CYC idle-low cycles.
// Every output is registered. Each output's next value is computed
// together with the next state.
module sequence_generator #(
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      PRE_W    = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(4'b1010),
  parameter int unsigned      GAP_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              out,
  output logic              out_valid,
  output logic              done
);

  localparam int unsigned MAX_PD = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int unsigned MAX_N  = (MAX_PD > GAP_CYC) ? MAX_PD : GAP_CYC;
  localparam int unsigned CNT_W  = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_W);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    PAY  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // bits/cycles already emitted in this state
  logic [DATA_W-1:0]   shreg_q, shreg_d; // payload bits still to send, next at MSB
  logic [PRE_W-1:0]    pre_q, pre_d;     // preamble bits still to send, next at MSB
  logic                out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  // Next-state and next-output logic. Outputs describe the cycle after the edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    pre_d       = pre_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    ready_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // The first preamble bit goes out in the cycle right after acceptance.
          state_d     = PRE;
          shreg_d     = data;
          out_d       = PREAMBLE[PRE_W-1];
          pre_d       = PREAMBLE << 1;
          out_valid_d = 1'b1;
          cnt_d       = CNT_ONE;
        end else begin
          ready_d = 1'b1;
        end
      end

      PRE: begin
        out_valid_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = PAY;
          out_d   = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
          cnt_d   = CNT_ONE;
        end else begin
          out_d = pre_q[PRE_W-1];
          pre_d = pre_q << 1;
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PAY: begin
        if (cnt_q == PAY_LAST) begin
          // done lines up with the first GAP cycle, or the first IDLE cycle.
          done_d = 1'b1;
          if (GAP_CYC > 0) begin
            state_d = GAP;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
          end
        end else begin
          out_valid_d = 1'b1;
          out_d       = shreg_q[DATA_W-1];
          shreg_d     = shreg_q << 1;
          cnt_d       = cnt_q + CNT_ONE;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      pre_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      pre_q       <= pre_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed testbench for sequence_generator with the default parameters
// (8-bit payload, 1010 preamble, 2 gap cycles). Inputs change on the
// falling edge. Outputs are sampled on the falling edge.
module tb_sequence_generator;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       ready;
  logic       out;
  logic       out_valid;
  logic       done;

  int vectors;
  int miscompares;

  sequence_generator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed bit against its expected value.
  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks every output in the current cycle.
  task automatic check_all(input string tag, input logic e_out, input logic e_vld,
                           input logic e_done, input logic e_rdy);
    check({tag, ".out"}, out, e_out);
    check({tag, ".out_valid"}, out_valid, e_vld);
    check({tag, ".done"}, done, e_done);
    check({tag, ".ready"}, ready, e_rdy);
  endtask

  // Checks the 12 valid cycles of a frame, starting at the current cycle.
  // On return the bench sits in the cycle after the last bit, where done pulses.
  task automatic check_frame(input string tag, input logic [11:0] bits);
    for (int k = 0; k < 12; k++) begin
      check_all($sformatf("%s.bit%0d", tag, k), bits[11-k], 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    check_all({tag, ".done_cycle"}, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  logic [3:0] hist;
  int         det_count;
  int         det_k;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b1;
    data        = 8'h00;

    // Test 1: reset held with start=1 keeps the idle outputs.
    #1;
    check_all("t1.async", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all($sformatf("t1.rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_all("t1.released", 1'b0, 1'b0, 1'b0, 1'b1);

    // Tests 2+3: A5 frame. A start with FF during the frame is ignored.
    data  = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = 8'h00;
    for (int k = 0; k < 12; k++) begin
      check_all($sformatf("t2.bit%0d", k), (12'hAA5 >> (11 - k)) & 1'b1, 1'b1, 1'b0, 1'b0);
      start = (k >= 3 && k <= 5);
      data  = (k >= 3 && k <= 5) ? 8'hFF : 8'h00;
      @(negedge clk);
    end
    start = 1'b0;
    check_all("t2.c13_done", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_all("t2.c14_gap", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("t2.c15_ready", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all($sformatf("t3.no_frame%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Test 4: start held high. 0F is accepted, then F0 is presented for the
    // next frame. The two GAP cycles are followed by the accepting IDLE cycle.
    data  = 8'h0F;
    start = 1'b1;
    @(negedge clk);
    data = 8'hF0;
    check_frame("t4.f1", 12'hA0F);
    @(negedge clk);
    check_all("t4.gap2", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("t4.accept", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    data = 8'h11;
    check_frame("t4.f2", 12'hAF0);
    start = 1'b0;
    @(negedge clk);
    check_all("t4.f2_gap2", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("t4.f2_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 5: asynchronous reset in cycle 7 of a frame, then a clean 3C frame.
    data  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    check_all("t5.c7_pre", 1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_all("t5.async", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_all("t5.held", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check_all("t5.released", 1'b0, 1'b0, 1'b0, 1'b1);
    data  = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_frame("t5.frame", 12'hA3C);

    // Test 6: data=00 into a reference 1010 detector on the serial line.
    @(negedge clk);
    @(negedge clk);
    check_all("t6.idle", 1'b0, 1'b0, 1'b0, 1'b1);
    hist      = 4'b0000;
    det_count = 0;
    det_k     = -1;
    data      = 8'h00;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      hist = {hist[2:0], out};
      if (hist == 4'b1010) begin
        det_count++;
        det_k = k;
      end
      @(negedge clk);
    end
    vectors++;
    assert (det_count == 1) else begin
      miscompares++;
      $error("FAIL t6.det_count: observed %0d expected 1", det_count);
    end
    vectors++;
    assert (det_k == 3) else begin
      miscompares++;
      $error("FAIL t6.det_cycle: observed %0d expected 3", det_k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
